dds_phase_ctrl: RTL

- Bus-programmable phase/sequence controller for the two-channel DA waveform path.
- Holds the frequency tuning word, channel-B phase offset and per-channel waveform select in synchronous registers; runs a 32-bit phase accumulator.
- Drives the 10-bit ROM addresses for channel A and channel B; these feed the waveform ROM/mux blocks.
- Supports continuous run and counted burst (N whole periods), with glitch-free, phase-coherent frequency updates.

---
 rtl/dds_phase_ctrl_pkg.sv | 43 ++++
 rtl/dds_phase_ctrl_if.sv | 10 +
 rtl/dds_bus_regs.sv | 52 +++++
 rtl/dds_phase_ctrl.sv | 106 ++++++++++
 4 files changed

// File: rtl/dds_phase_ctrl_pkg.sv
// Shared constants and types for the DDS phase/sequence controller:
// register map, CTRL bit layout, waveform codes and FSM encoding.
package dds_phase_ctrl_pkg;

    localparam int ACC_W  = 32;
    localparam int ROM_AW = 10;

    localparam logic [15:0] ADDR_FREQ_L = 16'h0008;
    localparam logic [15:0] ADDR_FREQ_H = 16'h0009;
    localparam logic [15:0] ADDR_PHASE  = 16'h000A;
    localparam logic [15:0] ADDR_CTRL   = 16'h000B;
    localparam logic [15:0] ADDR_WAVE   = 16'h000C;
    localparam logic [15:0] ADDR_BURST  = 16'h000D;

    localparam int CTRL_RUN   = 0;
    localparam int CTRL_CLR   = 1;
    localparam int CTRL_SYNC  = 2;
    localparam int CTRL_BURST = 3;

    localparam logic [7:0] WAVE_SIN = 8'd0;
    localparam logic [7:0] WAVE_SQU = 8'd1;
    localparam logic [7:0] WAVE_TRI = 8'd2;
    localparam logic [7:0] WAVE_SAW = 8'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    typedef struct packed {
        logic burst;
        logic sync;
        logic clr;
        logic run;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [3:0] bits);
        return '{burst: bits[CTRL_BURST], sync: bits[CTRL_SYNC],
                 clr: bits[CTRL_CLR], run: bits[CTRL_RUN]};
    endfunction

endpackage

// File: rtl/dds_phase_ctrl_if.sv
// Write-only register bus into the DDS controller (active-low chip select).
interface dds_phase_ctrl_if;
    logic        CS;
    logic        WR_EN;
    logic [15:0] ADDR;
    logic [15:0] DATA;

    modport master (output CS, WR_EN, ADDR, DATA);
    modport slave  (input  CS, WR_EN, ADDR, DATA);
endinterface

// File: rtl/dds_bus_regs.sv
// Bus decode plus the shadow tuning word, phase offset, waveform select and
// burst length registers. CTRL is decoded here but acted on by the top.
module dds_bus_regs
    import dds_phase_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    dds_phase_ctrl_if.slave      bus,
    output logic [ACC_W-1:0]     shadow_word,
    output logic                 freq_we,
    output logic                 ctrl_we,
    output ctrl_t                ctrl_cmd,
    output logic [ROM_AW-1:0]    phase_off,
    output logic [7:0]           wave_a,
    output logic [7:0]           wave_b,
    output logic [15:0]          burst_len
);

    logic wr;

    // NOTE: every output of an always_comb is assigned on every pass, so no latch can be inferred.
    always_comb begin
        wr       = !bus.CS && bus.WR_EN;
        freq_we  = wr && (bus.ADDR == ADDR_FREQ_L || bus.ADDR == ADDR_FREQ_H);
        ctrl_we  = wr && (bus.ADDR == ADDR_CTRL);
        ctrl_cmd = decode_ctrl(bus.DATA[3:0]);
    end

    // NOTE: state uses non-blocking assignments, and reset is sampled synchronously on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_word <= '0;
            phase_off   <= '0;
            wave_a      <= WAVE_SIN;
            wave_b      <= WAVE_SIN;
            burst_len   <= '0;
        end else if (wr) begin
            case (bus.ADDR)
                ADDR_FREQ_L: shadow_word[15:0]  <= bus.DATA;
                ADDR_FREQ_H: shadow_word[31:16] <= bus.DATA;
                ADDR_PHASE:  phase_off          <= bus.DATA[ROM_AW-1:0];
                ADDR_WAVE: begin
                    wave_a <= bus.DATA[7:0];
                    wave_b <= bus.DATA[15:8];
                end
                ADDR_BURST:  burst_len          <= bus.DATA;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dds_phase_ctrl.sv
// Phase accumulator, run/burst FSM and ROM address generation for the
// two-channel DDS path; register decode lives in dds_bus_regs.
module dds_phase_ctrl
    import dds_phase_ctrl_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST_N,
    dds_phase_ctrl_if.slave      bus,
    output logic [ROM_AW-1:0]    addr_a,
    output logic [ROM_AW-1:0]    addr_b,
    output logic [7:0]           wave_sel_a,
    output logic [7:0]           wave_sel_b,
    output logic                 sync_pulse,
    output logic                 running
);

    logic [ACC_W-1:0]  shadow_word, active, acc, acc_sum;
    logic [ROM_AW-1:0] phase_off;
    logic [15:0]       burst_len, burst_ctr;
    logic              freq_we, ctrl_we, pending, sync_mode;
    ctrl_t             ctrl_cmd;
    state_t            state;
    logic              carry, advance, clr, wrap, burst_fin, burst_done, copy;

    dds_bus_regs u_regs (
        .clk         (CLK),
        .rst_n       (RST_N),
        .bus         (bus),
        .shadow_word (shadow_word),
        .freq_we     (freq_we),
        .ctrl_we     (ctrl_we),
        .ctrl_cmd    (ctrl_cmd),
        .phase_off   (phase_off),
        .wave_a      (wave_sel_a),
        .wave_b      (wave_sel_b),
        .burst_len   (burst_len)
    );

    // A clear suppresses the wrap, so it neither pulses nor counts toward a burst.
    always_comb begin
        {carry, acc_sum} = {1'b0, acc} + {1'b0, active};
        advance    = (state == ST_RUN) || (state == ST_BURST && burst_len != '0);
        clr        = ctrl_we && ctrl_cmd.clr;
        wrap       = advance && carry && !clr;
        burst_fin  = (state == ST_BURST) && wrap && (burst_ctr + 16'd1 == burst_len);
        burst_done = (state == ST_BURST) && (burst_len == '0 || burst_fin);
        copy       = pending && (!sync_mode || wrap);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            running    <= 1'b0;
            acc        <= '0;
            active     <= '0;
            pending    <= 1'b0;
            sync_mode  <= 1'b0;
            burst_ctr  <= '0;
            sync_pulse <= 1'b0;
            addr_a     <= '0;
            addr_b     <= '0;
        end else begin
            // A CTRL write overrides a burst completing on the same edge.
            if (ctrl_we) begin
                sync_mode <= ctrl_cmd.sync;
                if (ctrl_cmd.run) begin
                    state   <= ctrl_cmd.burst ? ST_BURST : ST_RUN;
                    running <= 1'b1;
                end else begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                end
            end else if (burst_done) begin
                state   <= ST_IDLE;
                running <= 1'b0;
            end

            if (clr || (burst_fin && !ctrl_we)) begin
                acc <= '0;
            end else if (advance) begin
                acc <= acc_sum;
            end

            if (ctrl_we && ctrl_cmd.run && ctrl_cmd.burst) begin
                burst_ctr <= '0;
            end else if (state == ST_BURST && wrap) begin
                burst_ctr <= burst_ctr + 16'd1;
            end

            // The copied word only affects the increment after this edge.
            if (copy) begin
                active <= shadow_word;
            end
            if (freq_we) begin
                pending <= 1'b1;
            end else if (copy) begin
                pending <= 1'b0;
            end

            sync_pulse <= wrap;
            addr_a     <= acc[ACC_W-1 -: ROM_AW];
            addr_b     <= acc[ACC_W-1 -: ROM_AW] + phase_off;
        end
    end

endmodule
